arcsin_prep: RTL and testbench

ARCSIN_PREP -- requirements
Module: arcsin_prep

---
 rtl/arcsin_prep.sv | 105 ++++++++++
 tb/tb_arcsin_prep.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/arcsin_prep.sv
// Arcsin front end: signed Q1.15 sample -> sign + unsigned magnitude word (1.0 = 2^19) through a 2-entry FIFO.
// Optional ARCSIN_PREP_ROUND_EN: round the word to the nearest table index (clamped to index 16).
module arcsin_prep (
    input  logic        CLK_I,
    input  logic        RST_N_I,
    input  logic [15:0] SAMPLE_I,
    input  logic        VALID_I,
    output logic        READY_O,
    output logic [63:0] DATA_O,
    output logic        SIGN_O,
    output logic        VALID_O,
    input  logic        READY_I,
    output logic        SIGN_DLY_O,
    output logic [15:0] SAT_CNT_O
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned MAG_W    = SAMPLE_W + 1;
    localparam int unsigned WORD_W   = 20;
    localparam int unsigned SUM_W    = WORD_W + 1;
    localparam int unsigned OCC_W    = 2;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DATA_W   = 64;

    localparam logic [WORD_W-1:0] FULL_SCALE = WORD_W'(20'h80000);

    typedef struct packed {
        logic              sign;
        logic [WORD_W-1:0] word;
    } entry_t;

    logic signed [MAG_W-1:0] s_ext_c;
    logic [MAG_W-1:0]        mag_c;
    entry_t                  new_entry_c;
    entry_t                  slot0_q;
    entry_t                  slot1_q;
    logic [OCC_W-1:0]        occ_q;
    logic                    sign_dly_q;
    logic [CNT_W-1:0]        sat_cnt_q;
    logic                    push_c;
    logic                    pop_c;
`ifdef ARCSIN_PREP_ROUND_EN
    logic [SUM_W-1:0]        sum_c;
`endif

    // Magnitude/sign conversion of the incoming sample
    always_comb begin
        s_ext_c          = {SAMPLE_I[SAMPLE_W-1], SAMPLE_I};
        mag_c            = s_ext_c[MAG_W-1] ? MAG_W'(-s_ext_c) : MAG_W'(s_ext_c);
        new_entry_c.sign = SAMPLE_I[SAMPLE_W-1];
`ifdef ARCSIN_PREP_ROUND_EN
        sum_c = SUM_W'({mag_c, 4'b0000}) + SUM_W'(21'h4000);
        if (mag_c == '0)
            new_entry_c.word = '0;  // exact zero stays zero rather than taking the half-index offset
        else if (sum_c > SUM_W'(FULL_SCALE))
            new_entry_c.word = FULL_SCALE;
        else
            new_entry_c.word = WORD_W'(sum_c);
`else
        new_entry_c.word = WORD_W'({mag_c, 4'b0000});
`endif
    end

    assign READY_O    = (occ_q < OCC_W'(2));
    assign VALID_O    = (occ_q != OCC_W'(0));
    assign DATA_O     = DATA_W'(slot0_q.word);
    assign SIGN_O     = slot0_q.sign;
    assign SIGN_DLY_O = sign_dly_q;
    assign SAT_CNT_O  = sat_cnt_q;

    assign push_c = VALID_I && READY_O;
    assign pop_c  = VALID_O && READY_I;

    // Shift-style FIFO: slot0 is always the head so outputs come straight from a register
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            occ_q      <= '0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            sign_dly_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            sign_dly_q <= slot0_q.sign;
            if (pop_c && (slot0_q.word == FULL_SCALE) && (sat_cnt_q != '1))
                sat_cnt_q <= sat_cnt_q + CNT_W'(1);
            case ({push_c, pop_c})
                2'b10: begin
                    if (occ_q == OCC_W'(0))
                        slot0_q <= new_entry_c;
                    else
                        slot1_q <= new_entry_c;
                    occ_q <= occ_q + OCC_W'(1);
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    occ_q   <= occ_q - OCC_W'(1);
                end
                // Simultaneous push/pop only occurs at occupancy 1
                2'b11:   slot0_q <= new_entry_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arcsin_prep.sv
// Directed, table-driven bench for arcsin_prep; expectations follow ARCSIN_PREP_ROUND_EN when defined.
module tb_arcsin_prep;

    logic        CLK_I = 1'b0;
    logic        RST_N_I;
    logic [15:0] SAMPLE_I;
    logic        VALID_I;
    logic        READY_O;
    logic [63:0] DATA_O;
    logic        SIGN_O;
    logic        VALID_O;
    logic        READY_I;
    logic        SIGN_DLY_O;
    logic [15:0] SAT_CNT_O;

    int errors = 0;
    int checks = 0;
    int exp_sat = 0;

`ifdef ARCSIN_PREP_ROUND_EN
    localparam logic [19:0] RND = 20'h04000;
`else
    localparam logic [19:0] RND = 20'h00000;
`endif

    typedef struct {
        logic [15:0] sample;
        logic [19:0] w_trunc;
        logic [19:0] w_round;
        logic        sign;
    } vec_t;

    vec_t vecs[9];

    arcsin_prep dut (
        .CLK_I      (CLK_I),
        .RST_N_I    (RST_N_I),
        .SAMPLE_I   (SAMPLE_I),
        .VALID_I    (VALID_I),
        .READY_O    (READY_O),
        .DATA_O     (DATA_O),
        .SIGN_O     (SIGN_O),
        .VALID_O    (VALID_O),
        .READY_I    (READY_I),
        .SIGN_DLY_O (SIGN_DLY_O),
        .SAT_CNT_O  (SAT_CNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] exp_word(input vec_t v);
`ifdef ARCSIN_PREP_ROUND_EN
        return v.w_round;
`else
        return v.w_trunc;
`endif
    endfunction

    initial begin
        vecs[0] = '{16'h4000, 20'h40000, 20'h44000, 1'b0};  //  16384
        vecs[1] = '{16'h8000, 20'h80000, 20'h80000, 1'b1};  // -32768
        vecs[2] = '{16'h0000, 20'h00000, 20'h00000, 1'b0};  //  0
        vecs[3] = '{16'h0600, 20'h06000, 20'h0A000, 1'b0};  //  1536
        vecs[4] = '{16'h7FFF, 20'h7FFF0, 20'h80000, 1'b0};  //  32767
        vecs[5] = '{16'hFFFF, 20'h00010, 20'h04010, 1'b1};  // -1
        vecs[6] = '{16'h0064, 20'h00640, 20'h04640, 1'b0};  //  100
        vecs[7] = '{16'hC000, 20'h40000, 20'h44000, 1'b1};  // -16384
        vecs[8] = '{16'h0800, 20'h08000, 20'h0C000, 1'b0};  //  2048

        RST_N_I  = 1'b0;
        VALID_I  = 1'b0;
        SAMPLE_I = '0;
        READY_I  = 1'b1;

        #12;
        check("rst valid_o", 64'(VALID_O), 64'd0);
        check("rst data_o", DATA_O, 64'd0);
        check("rst sign_o", 64'(SIGN_O), 64'd0);
        check("rst sign_dly_o", 64'(SIGN_DLY_O), 64'd0);
        check("rst sat_cnt_o", 64'(SAT_CNT_O), 64'd0);
        @(negedge CLK_I);
        RST_N_I = 1'b1;
        @(posedge CLK_I); #1;
        check("post-rst ready_o", 64'(READY_O), 64'd1);

        // Single-sample conversions with immediate downstream acceptance
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK_I);
            SAMPLE_I = vecs[i].sample;
            VALID_I  = 1'b1;
            @(posedge CLK_I); #1;
            check($sformatf("vec%0d valid_o", i), 64'(VALID_O), 64'd1);
            check($sformatf("vec%0d data_o", i), DATA_O, 64'(exp_word(vecs[i])));
            check($sformatf("vec%0d sign_o", i), 64'(SIGN_O), 64'(vecs[i].sign));
            @(negedge CLK_I);
            VALID_I = 1'b0;
            @(posedge CLK_I); #1;
            if (exp_word(vecs[i]) == 20'h80000)
                exp_sat++;
            check($sformatf("vec%0d drained", i), 64'(VALID_O), 64'd0);
            check($sformatf("vec%0d sign_dly_o", i), 64'(SIGN_DLY_O), 64'(vecs[i].sign));
            check($sformatf("vec%0d sat_cnt_o", i), 64'(SAT_CNT_O), 64'(exp_sat));
        end

        // Backpressure: fill the FIFO, hold the third sample, then drain in order
        @(negedge CLK_I);
        READY_I  = 1'b0;
        SAMPLE_I = 16'd100;
        VALID_I  = 1'b1;
        @(posedge CLK_I); #1;
        check("bp first valid_o", 64'(VALID_O), 64'd1);
        check("bp first ready_o", 64'(READY_O), 64'd1);
        check("bp first data_o", DATA_O, 64'(20'h00640 + RND));
        @(negedge CLK_I);
        SAMPLE_I = 16'd200;
        @(posedge CLK_I); #1;
        check("bp full ready_o", 64'(READY_O), 64'd0);
        @(negedge CLK_I);
        SAMPLE_I = 16'd300;
        @(posedge CLK_I); #1;
        check("bp held ready_o", 64'(READY_O), 64'd0);
        check("bp held data_o", DATA_O, 64'(20'h00640 + RND));
        @(posedge CLK_I); #1;
        check("bp stable data_o", DATA_O, 64'(20'h00640 + RND));
        check("bp stable sign_o", 64'(SIGN_O), 64'd0);
        @(negedge CLK_I);
        READY_I = 1'b1;
        @(posedge CLK_I); #1;
        check("bp second data_o", DATA_O, 64'(20'h00C80 + RND));
        check("bp reopen ready_o", 64'(READY_O), 64'd1);
        @(posedge CLK_I); #1;
        check("bp third data_o", DATA_O, 64'(20'h012C0 + RND));
        check("bp third valid_o", 64'(VALID_O), 64'd1);
        @(negedge CLK_I);
        VALID_I = 1'b0;
        @(posedge CLK_I); #1;
        check("bp drained valid_o", 64'(VALID_O), 64'd0);

        // Mid-cycle reset discards buffered samples
        @(negedge CLK_I);
        READY_I  = 1'b0;
        SAMPLE_I = 16'h8000;
        VALID_I  = 1'b1;
        @(posedge CLK_I);
        @(negedge CLK_I);
        SAMPLE_I = 16'h0800;
        @(posedge CLK_I); #1;
        check("pre-rst full ready_o", 64'(READY_O), 64'd0);
        check("pre-rst sat_cnt_o", 64'(SAT_CNT_O), 64'(exp_sat));
        #3;
        RST_N_I = 1'b0;
        VALID_I = 1'b0;
        #1;
        exp_sat = 0;
        check("mid-rst valid_o", 64'(VALID_O), 64'd0);
        check("mid-rst sat_cnt_o", 64'(SAT_CNT_O), 64'(exp_sat));
        check("mid-rst data_o", DATA_O, 64'd0);
        check("mid-rst sign_dly_o", 64'(SIGN_DLY_O), 64'd0);
        @(negedge CLK_I);
        RST_N_I = 1'b1;
        READY_I = 1'b1;
        @(posedge CLK_I); #1;
        check("after-rst ready_o", 64'(READY_O), 64'd1);
        check("after-rst valid_o", 64'(VALID_O), 64'd0);
        @(negedge CLK_I);
        SAMPLE_I = 16'd50;
        VALID_I  = 1'b1;
        @(posedge CLK_I); #1;
        check("after-rst first valid_o", 64'(VALID_O), 64'd1);
        check("after-rst first data_o", DATA_O, 64'(20'h00320 + RND));
        check("after-rst first sign_o", 64'(SIGN_O), 64'd0);
        @(negedge CLK_I);
        VALID_I = 1'b0;
        @(posedge CLK_I); #1;
        check("after-rst drained valid_o", 64'(VALID_O), 64'd0);
        check("after-rst sat_cnt_o", 64'(SAT_CNT_O), 64'(exp_sat));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
